// File: rtl/code_frame_ctrl.sv
// Frame controller for the 2-out-of-5 code detector: deserialises 5-bit words,
// checks each, and counts legal/illegal words per frame. Optional early abort: CODE_FRAME_ABORT_EN.
module code_frame_ctrl #(
  parameter int NWORDS = 8,
  parameter int CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_ser_in,
  input  logic             i_ser_valid,
  output logic [4:0]       o_word,
  output logic             o_word_valid,
  output logic             o_word_ok,
  output logic [CNT_W-1:0] o_ok_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_busy,
  output logic             o_done
`ifdef CODE_FRAME_ABORT_EN
  ,
  output logic             o_aborted
`endif
);

  localparam int WC_W = (NWORDS < 2) ? 1 : $clog2(NWORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_sreg;
  logic [2:0]       r_bit_cnt;
  logic [WC_W-1:0]  r_word_cnt;
  logic [4:0]       r_word;
  logic             r_word_valid;
  logic             r_word_ok;
  logic [CNT_W-1:0] r_ok_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_done;

  logic       w_accept;
  logic       w_complete;
  logic [4:0] w_word;
  logic       w_ok;
  logic       w_last;
  logic       w_abort;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [2:0] popcnt5(input logic [4:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
  endfunction

  assign w_accept   = (r_state == S_SHIFT) && i_ser_valid;
  assign w_word     = {r_sreg, i_ser_in};
  assign w_complete = w_accept && (r_bit_cnt == 3'd4);
  assign w_ok       = (popcnt5(w_word) == 3'd2);
  assign w_last     = (r_word_cnt == WC_W'(NWORDS - 1));
`ifdef CODE_FRAME_ABORT_EN
  assign w_abort    = !w_ok;
`else
  assign w_abort    = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_SHIFT;
      S_SHIFT: if (w_complete && (w_last || w_abort)) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // word assembly, verdict and per-frame counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg       <= '0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_word_ok    <= 1'b0;
      r_ok_cnt     <= '0;
      r_err_cnt    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_word_valid <= w_complete;
      r_done       <= (r_state == S_FIN);
      if ((r_state == S_IDLE) && i_start) begin
        r_ok_cnt   <= '0;
        r_err_cnt  <= '0;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
      end else if (w_accept) begin
        r_sreg <= w_word[3:0];
        if (r_bit_cnt == 3'd4) begin
          r_bit_cnt  <= '0;
          r_word_cnt <= r_word_cnt + 1'b1;
          r_word     <= w_word;
          r_word_ok  <= w_ok;
          if (w_ok) r_ok_cnt  <= sat_inc(r_ok_cnt);
          else      r_err_cnt <= sat_inc(r_err_cnt);
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

`ifdef CODE_FRAME_ABORT_EN
  logic r_aborted;

  // FIN reached with an illegal last word only happens through an abort
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_aborted <= 1'b0;
    else if ((r_state == S_IDLE) && i_start) r_aborted <= 1'b0;
    else if ((r_state == S_FIN) && !r_word_ok) r_aborted <= 1'b1;
  end

  assign o_aborted = r_aborted;
`endif

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_word_ok    = r_word_ok;
  assign o_ok_cnt     = r_ok_cnt;
  assign o_err_cnt    = r_err_cnt;
  assign o_busy       = (r_state == S_SHIFT);
  assign o_done       = r_done;

endmodule

// File: tb/tb_code_frame_ctrl.sv
// Scoreboard bench for code_frame_ctrl; a second instance with CNT_W=2 shares the stimulus.
module tb_code_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ser_in = 1'b0;
  logic ser_valid = 1'b0;

  logic [4:0] a_word, b_word;
  logic       a_wv, a_ok, a_busy, a_done;
  logic       b_wv, b_ok, b_busy, b_done;
  logic [7:0] a_okc, a_errc;
  logic [1:0] b_okc, b_errc;
`ifdef CODE_FRAME_ABORT_EN
  logic a_aborted, b_aborted;
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  code_frame_ctrl #(.NWORDS(8), .CNT_W(8)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_ser_in(ser_in),
    .i_ser_valid(ser_valid), .o_word(a_word), .o_word_valid(a_wv),
    .o_word_ok(a_ok), .o_ok_cnt(a_okc), .o_err_cnt(a_errc),
    .o_busy(a_busy), .o_done(a_done)
`ifdef CODE_FRAME_ABORT_EN
    , .o_aborted(a_aborted)
`endif
  );

  code_frame_ctrl #(.NWORDS(8), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_ser_in(ser_in),
    .i_ser_valid(ser_valid), .o_word(b_word), .o_word_valid(b_wv),
    .o_word_ok(b_ok), .o_ok_cnt(b_okc), .o_err_cnt(b_errc),
    .o_busy(b_busy), .o_done(b_done)
`ifdef CODE_FRAME_ABORT_EN
    , .o_aborted(b_aborted)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] w;
    logic       ok;
    int         okc, errc, okc2, errc2;
    int         at;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_ok, m_err, m_ok2, m_err2, m_bits;
  logic [4:0] m_sh;
  bit m_abort;
  int exp_done_cyc = -1;
  int done_cnt = 0;
  logic [4:0] fr[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_wv) begin
        if (q.size() == 0) begin
          chk("spurious_word_valid", q.size(), 1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word", a_word, e.w);
          chk("word_ok", a_ok, e.ok);
          chk("ok_cnt", a_okc, e.okc);
          chk("err_cnt", a_errc, e.errc);
          chk("ok_cnt_w2", b_okc, e.okc2);
          chk("err_cnt_w2", b_errc, e.errc2);
          chk("wv_cycle", cyc, e.at);
        end
      end
      if (a_done) begin
        done_cnt++;
        chk("done_cycle", cyc, exp_done_cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      ser_valid = 1'b0;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    ser_valid = 1'b0;
    m_ok = 0; m_err = 0; m_ok2 = 0; m_err2 = 0; m_bits = 0; m_abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", a_busy, 1);
    chk("ok_cnt_cleared", a_okc, 0);
`ifdef CODE_FRAME_ABORT_EN
    chk("aborted_cleared", a_aborted, 0);
`endif
  endtask

  task automatic drive_bit(input logic b, input logic st);
    exp_t e;
    @(negedge clk);
    start = st;
    ser_valid = 1'b1;
    ser_in = b;
    m_sh = {m_sh[3:0], b};
    m_bits++;
    if (m_bits == 5) begin
      m_bits = 0;
      e.w = m_sh;
      e.ok = ($countones(m_sh) == 2);
      if (e.ok) begin
        if (m_ok < 255) m_ok++;
        if (m_ok2 < 3) m_ok2++;
      end else begin
        if (m_err < 255) m_err++;
        if (m_err2 < 3) m_err2++;
        if (ABORT) m_abort = 1'b1;
      end
      e.okc = m_ok; e.errc = m_err; e.okc2 = m_ok2; e.errc2 = m_err2;
      e.at = cyc + 1;
      q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [4:0] w, input int stall_after, input logic st);
    for (int k = 0; k < 5; k++) begin
      if (k == stall_after) idle(3);
      drive_bit(w[4-k], st);
    end
  endtask

  task automatic run_frame(input int stall_word);
    int pre;
    pre = done_cnt;
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_word(fr[i], (i == stall_word) ? 2 : -1, 1'b0);
      if (m_abort || i == 7) begin
        exp_done_cyc = cyc + 2;
        break;
      end
    end
    idle(5);
    chk("done_count", done_cnt, pre + 1);
    chk("final_ok_cnt", a_okc, m_ok);
    chk("final_err_cnt", a_errc, m_err);
    chk("final_ok_cnt_w2", b_okc, m_ok2);
    chk("final_err_cnt_w2", b_errc, m_err2);
    chk("busy_idle", a_busy, 0);
    chk("queue_drained", q.size(), 0);
`ifdef CODE_FRAME_ABORT_EN
    chk("aborted", a_aborted, m_abort);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d exceeded time limit", cyc);
    $fatal(1);
  end

  initial begin
    int pre;
    m_sh = '0;
    repeat (3) @(negedge clk);
    chk("rst_word", a_word, 0);
    chk("rst_wv", a_wv, 0);
    chk("rst_ok", a_ok, 0);
    chk("rst_okc", a_okc, 0);
    chk("rst_errc", a_errc, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    rst_n = 1'b1;
    idle(2);

    fr = '{5'b11000, 5'b01100, 5'b00011, 5'b00101, 5'b10100, 5'b01010, 5'b10001, 5'b00110};
    run_frame(-1);

    fr = '{5'b11111, 5'b00000, 5'b11110, 5'b00001, 5'b11000, 5'b11000, 5'b11000, 5'b11000};
    run_frame(-1);

    fr = '{5'b11000, 5'b01100, 5'b00011, 5'b00101, 5'b10100, 5'b01010, 5'b10001, 5'b00110};
    run_frame(4);

    // START pulses while busy, then reset two bits into word 3
    pre = done_cnt;
    do_start();
    send_word(5'b11000, -1, 1'b0);
    send_word(5'b01100, -1, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    ser_valid = 1'b0;
    start = 1'b0;
    #1;
    chk("midrst_okc", a_okc, 0);
    chk("midrst_busy", a_busy, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("postrst_word", a_word, 0);
    chk("postrst_ok", a_ok, 0);
    chk("postrst_errc", a_errc, 0);
    idle(6);
    chk("postrst_no_done", done_cnt, pre);
    chk("postrst_idle", a_busy, 0);

    fr = '{5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100};
    run_frame(-1);

    fr = '{5'b01100, 5'b11100, 5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100, 5'b01100};
    run_frame(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
